// File: rtl/err_event_logger.sv
// Error event logger: per-class saturating counters, a show-ahead log FIFO of
// error codes, and a two-state interrupt FSM driven by an error-rate window.
module err_event_logger #(
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 4,
    parameter int THRESH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       err_valid,
    input  logic [2:0]                 err_code,
    input  logic                       rd_en,
    input  logic                       irq_clr,
    output logic                       rd_valid,
    output logic [2:0]                 rd_code,
    output logic [$clog2(DEPTH):0]     log_count,
    output logic                       log_ovf,
    output logic [CNT_W-1:0]           parity_cnt,
    output logic [CNT_W-1:0]           timeout_cnt,
    output logic [CNT_W-1:0]           overflow_cnt,
    output logic [CNT_W-1:0]           multi_cnt,
    output logic                       irq,
    output logic                       fsm_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(THRESH + 1);

    typedef enum logic {IDLE = 1'b0, ALERT = 1'b1} state_t;

    state_t          state;
    logic [WW-1:0]   win;
    logic [2:0]      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic            is_par, is_tmo, is_ovf, is_multi;
    logic            full, do_pop, do_push;
    logic [PW-1:0]   next_rd_ptr;
    logic [CW-1:0]   next_count;
    logic [WW-1:0]   win_inc;

    always_comb begin
        is_par      = (err_code == 3'd0);
        is_tmo      = (err_code == 3'd3);
        is_ovf      = (err_code == 3'd5);
        is_multi    = !(is_par || is_tmo || is_ovf);
        full        = (log_count == CW'(DEPTH));
        do_pop      = rd_en && (log_count != '0);
        do_push     = err_valid && (!full || do_pop);
        next_rd_ptr = do_pop ? rd_ptr + PW'(1) : rd_ptr;
        next_count  = log_count + CW'(do_push) - CW'(do_pop);
        win_inc     = (win == WW'(THRESH)) ? win : win + WW'(1);
    end

    assign rd_valid  = (log_count != '0);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= err_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            log_count <= '0;
            log_ovf   <= 1'b0;
            rd_code   <= 3'd0;
        end else begin
            rd_ptr    <= next_rd_ptr;
            log_count <= next_count;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (err_valid && full && !rd_en) log_ovf <= 1'b1;
            // When the log drains to its new entry the head is the incoming code.
            if (do_push && (next_rd_ptr == wr_ptr)) rd_code <= err_code;
            else if (next_count != '0)             rd_code <= mem[next_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_cnt   <= '0;
            timeout_cnt  <= '0;
            overflow_cnt <= '0;
            multi_cnt    <= '0;
        end else if (err_valid) begin
            if (is_par   && parity_cnt   != '1) parity_cnt   <= parity_cnt   + CNT_W'(1);
            if (is_tmo   && timeout_cnt  != '1) timeout_cnt  <= timeout_cnt  + CNT_W'(1);
            if (is_ovf   && overflow_cnt != '1) overflow_cnt <= overflow_cnt + CNT_W'(1);
            if (is_multi && multi_cnt    != '1) multi_cnt    <= multi_cnt    + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            irq   <= 1'b0;
            win   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (err_valid) begin
                        win <= win_inc;
                        if ((win_inc == WW'(THRESH)) || is_multi) begin
                            state <= ALERT;
                            irq   <= 1'b1;
                        end
                    end
                end
                ALERT: begin
                    // An acknowledge that coincides with an event starts the new window at 1.
                    if (irq_clr) begin
                        if (err_valid) begin
                            win <= WW'(1);
                            if (is_multi || (THRESH == 1)) begin
                                state <= ALERT;
                                irq   <= 1'b1;
                            end else begin
                                state <= IDLE;
                                irq   <= 1'b0;
                            end
                        end else begin
                            win   <= '0;
                            state <= IDLE;
                            irq   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_err_event_logger.sv
// Vector table for err_event_logger (CNT_W=8, DEPTH=4, THRESH=3) plus a
// read-data queue checked on every accepted pop and a saturation run.
module tb_err_event_logger;
    logic       clk = 1'b0;
    logic       rst, err_valid, rd_en, irq_clr;
    logic [2:0] err_code;
    logic       rd_valid, log_ovf, irq, fsm_state;
    logic [2:0] rd_code;
    logic [2:0] log_count;
    logic [7:0] parity_cnt, timeout_cnt, overflow_cnt, multi_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic [2:0] exp_q[$];

    err_event_logger #(.CNT_W(8), .DEPTH(4), .THRESH(3)) dut (
        .clk(clk), .rst(rst), .err_valid(err_valid), .err_code(err_code),
        .rd_en(rd_en), .irq_clr(irq_clr), .rd_valid(rd_valid), .rd_code(rd_code),
        .log_count(log_count), .log_ovf(log_ovf), .parity_cnt(parity_cnt),
        .timeout_cnt(timeout_cnt), .overflow_cnt(overflow_cnt), .multi_cnt(multi_cnt),
        .irq(irq), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ev;
        logic [2:0] code;
        logic       rd, clr;
        logic       rv;
        logic [2:0] rc, cnt;
        logic       lovf;
        logic [7:0] p, t, o, m;
        logic       irq;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] c,
                                input logic rd, input logic clr, input logic rv,
                                input logic [2:0] rc, input logic [2:0] cnt,
                                input logic lovf, input logic [7:0] p, input logic [7:0] t,
                                input logic [7:0] o, input logic [7:0] m, input logic i);
        vec_t v;
        v.rst = r; v.ev = e; v.code = c; v.rd = rd; v.clr = clr;
        v.rv = rv; v.rc = rc; v.cnt = cnt; v.lovf = lovf;
        v.p = p; v.t = t; v.o = o; v.m = m; v.irq = i;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] c,
                         input logic rd, input logic clr);
        rst = r; err_valid = e; err_code = c; rd_en = rd; irq_clr = clr;
    endtask

    initial begin
        logic [2:0] prev_cnt;
        logic       popping;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        //                 rst ev code rd clr | rv rc cnt ovf  p  t  o  m irq
        vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0,  1, 0, 1, 0,  1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 3, 0, 0,  1, 0, 2, 0,  1, 1, 0, 0, 0);
        vecs[3]  = mk(0, 1, 5, 0, 0,  1, 0, 3, 0,  1, 1, 1, 0, 1);
        vecs[4]  = mk(0, 0, 0, 1, 0,  1, 3, 2, 0,  1, 1, 1, 0, 1);
        vecs[5]  = mk(0, 0, 0, 1, 0,  1, 5, 1, 0,  1, 1, 1, 0, 1);
        vecs[6]  = mk(0, 0, 0, 1, 0,  0, 5, 0, 0,  1, 1, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 1,  0, 5, 0, 0,  1, 1, 1, 0, 0);
        vecs[8]  = mk(0, 1, 3, 1, 0,  1, 3, 1, 0,  1, 2, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 1, 0,  0, 3, 0, 0,  1, 2, 1, 0, 0);
        vecs[10] = mk(0, 1, 7, 0, 0,  1, 7, 1, 0,  1, 2, 1, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 1,  1, 7, 1, 0,  1, 2, 1, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 1,  1, 7, 1, 0,  1, 2, 1, 1, 0);
        vecs[13] = mk(0, 0, 0, 1, 0,  0, 7, 0, 0,  1, 2, 1, 1, 0);
        vecs[14] = mk(0, 1, 3, 0, 0,  1, 3, 1, 0,  1, 3, 1, 1, 0);
        vecs[15] = mk(0, 1, 3, 0, 0,  1, 3, 2, 0,  1, 4, 1, 1, 0);
        vecs[16] = mk(0, 1, 3, 0, 0,  1, 3, 3, 0,  1, 5, 1, 1, 1);
        vecs[17] = mk(0, 1, 3, 0, 0,  1, 3, 4, 0,  1, 6, 1, 1, 1);
        vecs[18] = mk(0, 1, 3, 0, 0,  1, 3, 4, 1,  1, 7, 1, 1, 1);
        vecs[19] = mk(0, 1, 0, 1, 0,  1, 3, 4, 1,  2, 7, 1, 1, 1);
        vecs[20] = mk(0, 0, 0, 1, 0,  1, 3, 3, 1,  2, 7, 1, 1, 1);
        vecs[21] = mk(0, 0, 0, 1, 0,  1, 3, 2, 1,  2, 7, 1, 1, 1);
        vecs[22] = mk(0, 0, 0, 1, 0,  1, 0, 1, 1,  2, 7, 1, 1, 1);
        vecs[23] = mk(0, 0, 0, 1, 0,  0, 0, 0, 1,  2, 7, 1, 1, 1);
        vecs[24] = mk(0, 1, 5, 0, 0,  1, 5, 1, 1,  2, 7, 2, 1, 1);
        vecs[25] = mk(0, 1, 5, 0, 0,  1, 5, 2, 1,  2, 7, 3, 1, 1);
        vecs[26] = mk(0, 1, 5, 0, 0,  1, 5, 3, 1,  2, 7, 4, 1, 1);
        vecs[27] = mk(1, 1, 7, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[28] = mk(0, 1, 5, 1, 0,  1, 5, 1, 0,  0, 0, 1, 0, 0);
        vecs[29] = mk(0, 0, 0, 1, 0,  0, 5, 0, 0,  0, 0, 1, 0, 0);
        vecs[30] = mk(0, 1, 0, 0, 0,  1, 0, 1, 0,  1, 0, 1, 0, 0);
        vecs[31] = mk(0, 1, 0, 0, 0,  1, 0, 2, 0,  2, 0, 1, 0, 1);
        vecs[32] = mk(0, 1, 3, 0, 1,  1, 0, 3, 0,  2, 1, 1, 0, 0);
        vecs[33] = mk(0, 1, 3, 0, 0,  1, 0, 4, 0,  2, 2, 1, 0, 0);
        vecs[34] = mk(0, 1, 3, 0, 0,  1, 0, 4, 1,  2, 3, 1, 0, 1);

        prev_cnt = 3'd0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ev, vecs[i].code, vecs[i].rd, vecs[i].clr);
            popping = !vecs[i].rst && vecs[i].rd && (prev_cnt != 3'd0);
            if (vecs[i].rst) exp_q.delete();
            if (popping) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL sb_underflow[%0d]: got %0d expected queued entry", i, rd_code);
                end else check($sformatf("sb_head[%0d]", i), 64'(rd_code), 64'(exp_q.pop_front()));
            end
            if (!vecs[i].rst && vecs[i].ev && ((prev_cnt < 3'd4) || popping))
                exp_q.push_back(vecs[i].code);
            @(posedge clk);
            #1;
            check($sformatf("vec[%0d]", i),
                  64'({rd_valid, rd_code, log_count, log_ovf, parity_cnt, timeout_cnt,
                       overflow_cnt, multi_cnt, irq}),
                  64'({vecs[i].rv, vecs[i].rc, vecs[i].cnt, vecs[i].lovf, vecs[i].p,
                       vecs[i].t, vecs[i].o, vecs[i].m, vecs[i].irq}));
            prev_cnt = vecs[i].cnt;
        end

        // Saturation: 260 parity events while the log keeps draining.
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        for (int n = 1; n <= 260; n++) begin
            drive(1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            if (n == 254 || n == 255 || n == 260)
                check($sformatf("parity_sat[%0d]", n), 64'(parity_cnt), (n == 254) ? 64'd254 : 64'd255);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("sat_multi_zero", 64'(multi_cnt), 64'd0);
        check("sat_no_ovf", 64'(log_ovf), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/err_event_logger.md
ERR_EVENT_LOGGER -- requirements
Module: err_event_logger

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each per-class event counter.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries in the error log FIFO (power of 2, at least 2).
REQ-003 SHALL have parameter THRESH, default 3, errors per interrupt window that raise irq.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port err_valid  input  1  error event strobe, one event per cycle when high.
REQ-007 SHALL have port err_code  input  3  classified code: 0 parity, 3 timeout, 5 overflow, any other value is a multiple/unknown error.
REQ-008 SHALL have port rd_en  input  1  pop request for the log head.
REQ-009 SHALL have port irq_clr  input  1  interrupt acknowledge.
REQ-010 SHALL have port rd_valid  output  1  log non-empty; rd_code is meaningful.
REQ-011 SHALL have port rd_code  output  3  show-ahead head-of-log error code.
REQ-012 SHALL have port log_count  output  $clog2(DEPTH)+1  current log occupancy.
REQ-013 SHALL have port log_ovf  output  1  sticky flag: at least one event was dropped.
REQ-014 SHALL have ports parity_cnt, timeout_cnt, overflow_cnt, multi_cnt  output  CNT_W each  per-class event counts.
REQ-015 SHALL have port irq  output  1  interrupt request, level.

Function
REQ-016 SHALL classify each event with err_valid=1 by err_code exactly per REQ-007 and increment exactly one class counter.
REQ-017 SHALL saturate each class counter at 2^CNT_W-1; no wrap to 0.
REQ-018 SHALL make counter, log_count and rd_code updates visible on the cycle after the event is sampled (latency 1).
REQ-019 SHALL push err_code into the log on every event while log_count < DEPTH.
REQ-020 SHALL, on an event with log full and rd_en=0, drop the entry, still increment the class counter, and set log_ovf.
REQ-021 SHALL, on an event with log full and rd_en=1, perform the pop and accept the push; log_count stays DEPTH; log_ovf unchanged.
REQ-022 SHALL, on rd_en=1 with rd_valid=1, remove the head; next entry appears on rd_code the following cycle.
REQ-023 SHALL ignore rd_en when the log is empty, including when a push occurs in the same cycle (log_count becomes 1).
REQ-024 SHALL hold rd_code at its last value while the log is empty; rd_valid = (log_count != 0).
REQ-025 SHALL wrap read and write pointers modulo DEPTH; log preserves arrival order.
REQ-026 SHALL implement interrupt FSM with states IDLE (irq=0) and ALERT (irq=1) and an internal window counter, saturating at THRESH.
REQ-027 SHALL, in IDLE, increment the window counter per event and enter ALERT on the cycle after the event that brings it to THRESH or on any multiple/unknown-code event.
REQ-028 SHALL, in ALERT, remain there until irq_clr=1; then return to IDLE and reset the window counter to 0.
REQ-029 SHALL, when irq_clr and an event coincide in ALERT, return to IDLE with window counter = 1 (or re-enter ALERT immediately next cycle if the event is multiple/unknown or THRESH=1).
REQ-030 SHALL ignore irq_clr in IDLE; log_ovf is cleared only by reset.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, clear all counters, window counter, pointers, log_count, log_ovf, rd_code to 0, and set FSM to IDLE (irq=0, rd_valid=0).
REQ-032 SHALL give rst priority over err_valid, rd_en and irq_clr in the same cycle; mid-operation reset discards all log contents.

Verification
REQ-033 SHALL cover: events 0,3,5 on consecutive cycles -> parity/timeout/overflow_cnt = 1 each, log_count=3, reads return 0,3,5 in order, irq=1 one cycle after third event.
REQ-034 SHALL cover: single event code 7 -> multi_cnt=1, irq=1 next cycle; irq_clr pulse -> irq=0 next cycle.
REQ-035 SHALL cover: 5 events code 3 with no reads (DEPTH=4) -> log_count=4, log_ovf=1, timeout_cnt=5; then event with rd_en=1 -> log_count stays 4, head advances.
REQ-036 SHALL cover: 260 parity events with CNT_W=8 -> parity_cnt holds 255.
REQ-037 SHALL cover: rd_en with empty log plus simultaneous event code 5 -> log_count=1, rd_code=5 next cycle.
REQ-038 SHALL cover: rst asserted with log_count=3, irq=1 and concurrent event -> all outputs 0 next cycle.
